// File: rtl/rtype_sequencer_pkg.sv
// Shared constants for the R-type sequencer: opcode/funct fields, ALU select
// codes and the sequencer state encoding.
package rtype_sequencer_pkg;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decoder: maps an instruction word to an ALU select
// code and flags whether it is a supported R-type operation.
module rtype_decoder
    import rtype_sequencer_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  alu_control,
    output logic        legal
);

    always_comb begin
        alu_control = 4'b0000;
        legal       = 1'b0;
        if (instr[6:0] == OPCODE_RTYPE) begin
            legal = 1'b1;
            case ({instr[31:25], instr[14:12]})
                {F7_BASE, F3_ADD_SUB}: alu_control = ALU_ADD;
                {F7_ALT,  F3_ADD_SUB}: alu_control = ALU_SUB;
                {F7_BASE, F3_AND}:     alu_control = ALU_AND;
                {F7_BASE, F3_OR}:      alu_control = ALU_OR;
                {F7_BASE, F3_XOR}:     alu_control = ALU_XOR;
                {F7_BASE, F3_SLL}:     alu_control = ALU_SLL;
                {F7_BASE, F3_SRL_SRA}: alu_control = ALU_SRL;
                {F7_ALT,  F3_SRL_SRA}: alu_control = ALU_SRA;
                {F7_BASE, F3_SLT}:     alu_control = ALU_SLT;
                {F7_BASE, F3_SLTU}:    alu_control = ALU_SLTU;
                default:               legal       = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/rtype_sequencer.sv
// Sequences one R-type instruction at a time through READ/WRITE/RESP,
// driving register-file selects and returning a completion response.
module rtype_sequencer
    import rtype_sequencer_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [4:0]         read_reg_num1,
    output logic [4:0]         read_reg_num2,
    output logic [4:0]         write_reg,
    output logic [3:0]         alu_control,
    output logic               regwrite,
    input  logic               zero_flag,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_zero,
    output logic               resp_illegal,
    output logic [COUNT_W-1:0] instr_count
);

    state_t     state;
    logic       legal_q;
    logic [3:0] dec_alu;
    logic       dec_legal;

    rtype_decoder u_decoder (
        .instr       (instr),
        .alu_control (dec_alu),
        .legal       (dec_legal)
    );

    // The select outputs themselves hold the latched instruction fields, so
    // later changes on instr cannot disturb the in-flight operation.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= S_IDLE;
            instr_ready   <= 1'b1;
            legal_q       <= 1'b0;
            read_reg_num1 <= 5'd0;
            read_reg_num2 <= 5'd0;
            write_reg     <= 5'd0;
            alu_control   <= 4'd0;
            regwrite      <= 1'b0;
            resp_valid    <= 1'b0;
            resp_zero     <= 1'b0;
            resp_illegal  <= 1'b0;
            instr_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        state         <= S_READ;
                        instr_ready   <= 1'b0;
                        legal_q       <= dec_legal;
                        read_reg_num1 <= instr[19:15];
                        read_reg_num2 <= instr[24:20];
                        write_reg     <= instr[11:7];
                        alu_control   <= dec_alu;
                    end
                end
                S_READ: begin
                    if (legal_q) begin
                        state    <= S_WRITE;
                        regwrite <= (write_reg != 5'd0);
                    end else begin
                        state         <= S_RESP;
                        read_reg_num1 <= 5'd0;
                        read_reg_num2 <= 5'd0;
                        write_reg     <= 5'd0;
                        alu_control   <= 4'd0;
                        resp_valid    <= 1'b1;
                        resp_zero     <= 1'b0;
                        resp_illegal  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state         <= S_RESP;
                    regwrite      <= 1'b0;
                    read_reg_num1 <= 5'd0;
                    read_reg_num2 <= 5'd0;
                    write_reg     <= 5'd0;
                    alu_control   <= 4'd0;
                    resp_valid    <= 1'b1;
                    resp_zero     <= zero_flag;
                    resp_illegal  <= 1'b0;
                    instr_count   <= instr_count + COUNT_W'(1);
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state       <= S_IDLE;
                        resp_valid  <= 1'b0;
                        instr_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtype_sequencer.sv
// Self-checking bench for rtype_sequencer: directed vector table, hand-written
// reset/stall sequences and randomized instructions against a reference model.
module tb_rtype_sequencer;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [4:0]    read_reg_num1;
    logic [4:0]    read_reg_num2;
    logic [4:0]    write_reg;
    logic [3:0]    alu_control;
    logic          regwrite;
    logic          zero_flag;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_zero;
    logic          resp_illegal;
    logic [CW-1:0] instr_count;

    int total = 0;
    int bad   = 0;
    int cnt_model = 0;

    always #5 clock = ~clock;

    rtype_sequencer #(.COUNT_W(CW)) dut (
        .clock         (clock),
        .reset         (reset),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .read_reg_num1 (read_reg_num1),
        .read_reg_num2 (read_reg_num2),
        .write_reg     (write_reg),
        .alu_control   (alu_control),
        .regwrite      (regwrite),
        .zero_flag     (zero_flag),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_zero     (resp_zero),
        .resp_illegal  (resp_illegal),
        .instr_count   (instr_count)
    );

    // Reference table of supported operations: funct7, funct3, ALU code.
    typedef struct {
        logic [6:0] f7;
        logic [2:0] f3;
        logic [3:0] code;
    } op_t;
    op_t ops[10];

    typedef struct {
        logic [31:0] w;
        bit          zf;
        int          hold;
        bit          legal;
        logic [3:0]  code;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    task automatic ref_decode(input logic [31:0] w, output bit legal, output logic [3:0] code);
        legal = 0;
        code  = 4'd0;
        if (w[6:0] == 7'b0110011)
            foreach (ops[i])
                if (ops[i].f7 == w[31:25] && ops[i].f3 == w[14:12]) begin
                    legal = 1;
                    code  = ops[i].code;
                end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offers one instruction and follows it through to the end of its response.
    task automatic run_txn(input logic [31:0] w, input bit zf, input int hold,
                           input bit legal, input logic [3:0] code);
        logic [4:0] rs1, rs2, rd;
        bit         zsnap;
        rs1 = w[19:15];
        rs2 = w[24:20];
        rd  = w[11:7];
        chk("ready_idle", instr_ready, 1);
        instr       = w;
        instr_valid = 1'b1;
        zero_flag   = zf;
        resp_ready  = (hold == 0);
        tick();
        instr       = $urandom;
        chk("rs1_read", read_reg_num1, rs1);
        chk("rs2_read", read_reg_num2, rs2);
        chk("rd_read", write_reg, rd);
        chk("alu_read", alu_control, legal ? code : 4'd0);
        chk("regwrite_read", regwrite, 0);
        chk("ready_busy", instr_ready, 0);
        chk("respv_read", resp_valid, 0);
        tick();
        instr = $urandom;
        if (legal) begin
            chk("regwrite_write", regwrite, (rd != 0));
            chk("rs1_write", read_reg_num1, rs1);
            chk("alu_write", alu_control, code);
            chk("respv_write", resp_valid, 0);
            tick();
            cnt_model = (cnt_model + 1) % (1 << CW);
            chk("regwrite_off", regwrite, 0);
            chk("resp_zero", resp_zero, zf);
        end else begin
            chk("regwrite_ill", regwrite, 0);
            chk("resp_zero_ill", resp_zero, 0);
        end
        chk("respv", resp_valid, 1);
        chk("resp_illegal", resp_illegal, !legal);
        chk("sel_resp", {read_reg_num1, read_reg_num2, write_reg, alu_control}, 0);
        chk("count", instr_count, cnt_model);
        instr_valid = 1'b0;
        zsnap = resp_zero;
        for (int k = 0; k < hold; k++) begin
            zero_flag = ~zero_flag;
            tick();
            chk("respv_hold", resp_valid, 1);
            chk("rzero_hold", resp_zero, zsnap);
            chk("ready_hold", instr_ready, 0);
        end
        resp_ready = 1'b1;
        tick();
        chk("respv_done", resp_valid, 0);
        chk("ready_done", instr_ready, 1);
    endtask

    initial begin
        bit          lg;
        logic [3:0]  cd;
        logic [31:0] w;

        ops[0] = '{7'h00, 3'b000, 4'b0010};
        ops[1] = '{7'h20, 3'b000, 4'b0110};
        ops[2] = '{7'h00, 3'b111, 4'b0000};
        ops[3] = '{7'h00, 3'b110, 4'b0001};
        ops[4] = '{7'h00, 3'b100, 4'b0011};
        ops[5] = '{7'h00, 3'b001, 4'b0100};
        ops[6] = '{7'h00, 3'b101, 4'b0101};
        ops[7] = '{7'h20, 3'b101, 4'b0111};
        ops[8] = '{7'h00, 3'b010, 4'b1000};
        ops[9] = '{7'h00, 3'b011, 4'b1001};

        vecs[0]  = '{32'h402081B3,                          0, 0, 1, 4'b0110};
        vecs[1]  = '{rtype(7'h00, 1, 1, 3'b000, 0, 7'h33),  1, 0, 1, 4'b0010};
        vecs[2]  = '{rtype(7'h00, 7, 6, 3'b111, 5, 7'h33),  0, 0, 1, 4'b0000};
        vecs[3]  = '{rtype(7'h00, 9, 8, 3'b110, 10, 7'h33), 1, 1, 1, 4'b0001};
        vecs[4]  = '{rtype(7'h00, 2, 4, 3'b100, 31, 7'h33), 0, 0, 1, 4'b0011};
        vecs[5]  = '{rtype(7'h00, 3, 3, 3'b001, 12, 7'h33), 0, 0, 1, 4'b0100};
        vecs[6]  = '{rtype(7'h00, 5, 17, 3'b101, 7, 7'h33), 1, 0, 1, 4'b0101};
        vecs[7]  = '{rtype(7'h20, 5, 17, 3'b101, 8, 7'h33), 0, 0, 1, 4'b0111};
        vecs[8]  = '{rtype(7'h00, 21, 22, 3'b010, 23, 7'h33), 0, 0, 1, 4'b1000};
        vecs[9]  = '{rtype(7'h00, 24, 25, 3'b011, 26, 7'h33), 0, 0, 1, 4'b1001};
        vecs[10] = '{rtype(7'h00, 1, 2, 3'b000, 3, 7'h13),  1, 0, 0, 4'b0000};
        vecs[11] = '{rtype(7'h20, 1, 2, 3'b111, 3, 7'h33),  1, 2, 0, 4'b0000};
        vecs[12] = '{rtype(7'h01, 1, 2, 3'b000, 3, 7'h33),  0, 0, 0, 4'b0000};
        vecs[13] = '{rtype(7'h00, 11, 12, 3'b000, 13, 7'h33), 1, 5, 1, 4'b0010};

        reset       = 1'b0;
        instr       = 32'h0;
        instr_valid = 1'b0;
        zero_flag   = 1'b0;
        resp_ready  = 1'b0;
        tick();
        tick();
        chk("rst_ready", instr_ready, 1);
        chk("rst_outs", {read_reg_num1, read_reg_num2, write_reg, alu_control,
                         regwrite, resp_valid, resp_zero, resp_illegal}, 0);
        chk("rst_count", instr_count, 0);
        reset = 1'b1;
        tick();

        foreach (vecs[i])
            run_txn(vecs[i].w, vecs[i].zf, vecs[i].hold, vecs[i].legal, vecs[i].code);

        // Abort a SUB while it sits in WRITE, then run an XOR straight after.
        chk("pre_abort_count_nz", (instr_count != 0), 1);
        instr       = 32'h402081B3;
        instr_valid = 1'b1;
        resp_ready  = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("abort_in_write", regwrite, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cnt_model = 0;
        chk("abort_regwrite", regwrite, 0);
        chk("abort_respv", resp_valid, 0);
        chk("abort_count", instr_count, 0);
        chk("abort_ready", instr_ready, 1);
        run_txn(rtype(7'h00, 2, 1, 3'b100, 4, 7'h33), 0, 0, 1, 4'b0011);

        // Counter wrap on the narrow build: 15 -> 0 -> 1.
        for (int i = 0; i < 14; i++)
            run_txn(rtype(7'h00, 1, 1, 3'b000, 2, 7'h33), 0, 0, 1, 4'b0010);
        chk("wrap_15", instr_count, 15);
        run_txn(rtype(7'h00, 1, 1, 3'b000, 2, 7'h33), 0, 0, 1, 4'b0010);
        chk("wrap_0", instr_count, 0);
        run_txn(rtype(7'h00, 1, 1, 3'b000, 0, 7'h33), 0, 0, 1, 4'b0010);
        chk("wrap_1", instr_count, 1);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    int k;
                    k = $urandom_range(0, 9);
                    w = rtype(ops[k].f7, 5'($urandom), 5'($urandom), ops[k].f3,
                              5'($urandom), 7'h33);
                end
                1: w = rtype(($urandom_range(0, 1) == 0) ? 7'h20 : 7'($urandom),
                             5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h33);
                default: w = $urandom;
            endcase
            ref_decode(w, lg, cd);
            run_txn(w, 1'($urandom), $urandom_range(0, 2), lg, cd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
